clock_source_ctrl: RTL and testbench
====================================

Name: clock_source_ctrl

Overview:
- Sequences selection of the system clock source between the internal-oscillator PLL path and the external 10MHz reference PLL path.
- Runs on the always-running internal oscillator clock (clk_debug, nominal 9.85MHz). It qualifies the external reference by frequency measurement and drives the PLL input mux select.
- Holds downstream logic in reset across every switchover and falls back to internal automatically on reference loss or PLL unlock.

Parameters:
- WINDOW_LEN, 4096, measurement window length in clk_debug cycles.
- EXP_EDGES, 260, expected ref_toggle transitions per window (10MHz/16 toggle rate → 625k transitions/s × 415.8us).
- TOL, 8, accepted absolute deviation from EXP_EDGES.
- QUAL_WINDOWS, 4, consecutive good windows required before switching to external.
- HOLD_CYC, 64, minimum sys_hold assertion after any clk_sel change.
- LOCK_TIMEOUT, 16384, maximum cycles waiting for pll_lock before abandoning a switch.
- CNT_W, 12, edge counter width (saturating).

Ports:
- clk_debug  in  1  controller clock, internal oscillator, never switched.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = external reference permitted.
- force_int  in  1  1 = force internal source, overrides everything.
- ref_toggle  in  1  asynchronous toggle from clk_10M_ref domain, inverts every 16 reference cycles.
- pll_lock  in  1  asynchronous LOCK from the system PLL.
- clk_sel  out  1  PLL input mux select: 0 = internal, 1 = external.
- sys_hold  out  1  reset to clk_2M5-domain logic.
- ref_ok  out  1  last completed window good.
- ref_count  out  CNT_W  edge count of the last completed window.
- state  out  3  current FSM state code, for Reveal.

Behaviour:
- Both ref_toggle and pll_lock pass through 2-FF synchronisers. A third register on synced ref_toggle provides edge detection; each transition counts as one edge.
- Window counter runs 0..WINDOW_LEN-1 continuously from reset in every state.
- Edge counter saturates at 2^CNT_W-1.
- On the terminal cycle, ref_count and ref_ok latch (good = count within EXP_EDGES±TOL inclusive), and the edge counter restarts at 0, or at 1 if an edge occurs in that same cycle.
- good_streak increments on each good window, saturating at QUAL_WINDOWS. It clears on a bad window, in FALLBACK, and when enable=0.
- Reset values: clk_sel=0, sys_hold=1, ref_ok=0, ref_count=0, state=HOLD_INT, all counters 0.
- FSM codes: HOLD_INT=0, INT=1, SWITCH=2, EXT=3, FALLBACK=4.
- HOLD_INT: clk_sel=0, sys_hold=1. Go to INT once hold counter ≥ HOLD_CYC-1 AND pll_lock_s=1.
- INT: clk_sel=0, sys_hold=0.
  - pll_lock_s=0 → HOLD_INT.
  - Else if enable=1, force_int=0 and good_streak=QUAL_WINDOWS → SWITCH.
- SWITCH: clk_sel=1, sys_hold=1; hold and timeout counters cleared on entry.
  - Go to EXT when hold counter ≥ HOLD_CYC-1 AND pll_lock_s=1.
  - Go to FALLBACK on timeout counter = LOCK_TIMEOUT-1, on force_int, on enable=0, or on a bad window end.
- EXT: clk_sel=1, sys_hold=0. Go to FALLBACK on bad window end, pll_lock_s=0, force_int=1 or enable=0.
- FALLBACK: clk_sel=0, sys_hold=1, good_streak cleared. Go to HOLD_INT after one cycle; HOLD_INT restarts its hold count on entry.
- All outputs are registered. Each FSM transition takes effect on the clock edge after its condition is sampled, and clk_sel/sys_hold change in the same cycle as state.
- Priority when events coincide: reset > force_int > pll_lock loss > bad window > qualification.
- sys_hold is asserted no later than the cycle clk_sel changes, in both directions; no output cycle ever shows clk_sel changed with sys_hold=0.
- Mid-operation reset returns to HOLD_INT with clk_sel=0 on the next edge.

Test Plan:
- Reset, pll_lock=1 after 10 cycles, no ref_toggle → sys_hold releases at cycle ≥HOLD_CYC; INT; ref_count=0, ref_ok=0 each window; clk_sel stays 0.
- enable=1, ref_toggle transitions every 15.76 cycles (260/window), pll_lock held 1 → ref_ok=1 from window 1; SWITCH on the cycle after window 4 ends; EXT after 64 cycles; clk_sel=1, sys_hold=0.
- In EXT, drop ref_toggle activity → window end gives ref_count well below 252, ref_ok=0 → FALLBACK then HOLD_INT; clk_sel=0 with sys_hold=1 in the same cycle; INT after 64 cycles.
- Boundary counts 252, 268, 251, 269 per window → ref_ok = 1, 1, 0, 0; the bad windows reset good_streak.
- In SWITCH, pll_lock held 0 → FALLBACK exactly at LOCK_TIMEOUT; force_int=1 asserted in the same cycle as a window-4 qualification → no SWITCH entry.
- Assert reset for one cycle while in EXT → next cycle state=0, clk_sel=0, sys_hold=1, ref_count=0.

Source files
------------

// File: rtl/clock_source_ctrl_if.sv
// Pin bundle between the clock-source controller and its surroundings:
// reference/lock inputs, policy controls, and the registered status outputs.
interface clock_source_ctrl_if #(
    parameter int CNT_W = 12
);
    logic             enable;
    logic             force_int;
    logic             ref_toggle;
    logic             pll_lock;
    logic             clk_sel;
    logic             sys_hold;
    logic             ref_ok;
    logic [CNT_W-1:0] ref_count;
    logic [2:0]       state;

    modport master (
        output enable, force_int, ref_toggle, pll_lock,
        input  clk_sel, sys_hold, ref_ok, ref_count, state
    );

    modport slave (
        input  enable, force_int, ref_toggle, pll_lock,
        output clk_sel, sys_hold, ref_ok, ref_count, state
    );
endinterface

// File: rtl/clock_source_ctrl.sv
// Qualifies the external 10MHz reference by edge counting on clk_debug and sequences
// the PLL input mux between internal and external sources, holding clk_2M5 logic in reset.
module clock_source_ctrl #(
    parameter int WINDOW_LEN   = 4096,
    parameter int EXP_EDGES    = 260,
    parameter int TOL          = 8,
    parameter int QUAL_WINDOWS = 4,
    parameter int HOLD_CYC     = 64,
    parameter int LOCK_TIMEOUT = 16384,
    parameter int CNT_W        = 12
) (
    input logic                clk_debug,
    input logic                reset,
    clock_source_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        HOLD_INT = 3'd0,
        INT      = 3'd1,
        SWITCH   = 3'd2,
        EXT      = 3'd3,
        FALLBACK = 3'd4
    } state_t;

    localparam int WIN_W    = $clog2(WINDOW_LEN);
    localparam int HOLD_W   = $clog2(HOLD_CYC + 1);
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam int STREAK_W = $clog2(QUAL_WINDOWS + 1);

    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]    LO_EDGES = CNT_W'(EXP_EDGES - TOL);
    localparam logic [CNT_W-1:0]    HI_EDGES = CNT_W'(EXP_EDGES + TOL);
    localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [HOLD_W-1:0]   HOLD_MIN = HOLD_W'(HOLD_CYC - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] QUAL     = STREAK_W'(QUAL_WINDOWS);

    logic                ref_meta, ref_s, ref_d;
    logic                lock_meta, lock_s;
    logic [WIN_W-1:0]    win_cnt;
    logic [CNT_W-1:0]    edge_cnt;
    logic [STREAK_W-1:0] good_streak;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [CNT_W-1:0]    ref_count_q;
    logic                ref_ok_q;
    logic                clk_sel_q, sys_hold_q;
    logic                clk_sel_d, sys_hold_d;
    state_t              state_q, state_d;

    logic edge_seen, win_end, win_good, win_bad, hold_done, tmo_done;

    // NOTE: synchroniser flops carry no reset so a reset pulse never fabricates a reference edge.
    // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
    always_ff @(posedge clk_debug) begin
        ref_meta  <= bus.ref_toggle;
        ref_s     <= ref_meta;
        ref_d     <= ref_s;
        lock_meta <= bus.pll_lock;
        lock_s    <= lock_meta;
    end

    assign edge_seen = ref_s ^ ref_d;
    assign win_end   = (win_cnt == WIN_LAST);
    assign win_good  = (edge_cnt >= LO_EDGES) && (edge_cnt <= HI_EDGES);
    assign win_bad   = win_end && !win_good;
    assign hold_done = (hold_cnt >= HOLD_MIN);
    assign tmo_done  = (tmo_cnt == TMO_LAST);

    // An edge landing on the terminal cycle is credited to the next window.
    always_ff @(posedge clk_debug) begin
        if (reset) begin
            win_cnt     <= '0;
            edge_cnt    <= '0;
            ref_count_q <= '0;
            ref_ok_q    <= 1'b0;
            good_streak <= '0;
        end else begin
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            if (win_end) begin
                ref_count_q <= edge_cnt;
                ref_ok_q    <= win_good;
                edge_cnt    <= CNT_W'(edge_seen);
            end else if (edge_seen && edge_cnt != CNT_MAX) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (state_q == FALLBACK || !bus.enable || win_bad)
                good_streak <= '0;
            else if (win_end && good_streak != QUAL)
                good_streak <= good_streak + 1'b1;
        end
    end

    // NOTE: next-state and decoded outputs get defaults first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLD_INT: if (hold_done && lock_s) state_d = INT;
            INT: begin
                if (!lock_s)
                    state_d = HOLD_INT;
                else if (bus.enable && !bus.force_int && good_streak == QUAL)
                    state_d = SWITCH;
            end
            SWITCH: begin
                if (bus.force_int || !bus.enable || win_bad || tmo_done)
                    state_d = FALLBACK;
                else if (hold_done && lock_s)
                    state_d = EXT;
            end
            EXT: if (bus.force_int || !lock_s || win_bad || !bus.enable) state_d = FALLBACK;
            FALLBACK: state_d = HOLD_INT;
            default:  state_d = HOLD_INT;
        endcase
        // Decoding from the next state keeps clk_sel/sys_hold aligned with the state register.
        clk_sel_d  = (state_d == SWITCH) || (state_d == EXT);
        sys_hold_d = (state_d != INT) && (state_d != EXT);
    end

    always_ff @(posedge clk_debug) begin
        if (reset) begin
            state_q    <= HOLD_INT;
            clk_sel_q  <= 1'b0;
            sys_hold_q <= 1'b1;
            hold_cnt   <= '0;
            tmo_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            clk_sel_q  <= clk_sel_d;
            sys_hold_q <= sys_hold_d;
            if (state_d != state_q) begin
                hold_cnt <= '0;
                tmo_cnt  <= '0;
            end else begin
                if (!hold_done)
                    hold_cnt <= hold_cnt + 1'b1;
                if (state_q == SWITCH && !tmo_done)
                    tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign bus.clk_sel   = clk_sel_q;
    assign bus.sys_hold  = sys_hold_q;
    assign bus.ref_ok    = ref_ok_q;
    assign bus.ref_count = ref_count_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_clock_source_ctrl.sv
// Directed bench: reference toggles are placed at fixed offsets inside each 4096-cycle
// window so every window count, state change and cycle of latency is known in advance.
module tb_clock_source_ctrl;
    localparam int WIN = 4096;

    logic clk_debug = 1'b0;
    logic reset;

    clock_source_ctrl_if #(.CNT_W(12)) bus ();

    clock_source_ctrl dut (
        .clk_debug (clk_debug),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_debug = ~clk_debug;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   n_edges     = 0;
    logic last_sel    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input bit sel, input bit hold);
        check({tag, ".state"},    32'(bus.state),    32'(st));
        check({tag, ".clk_sel"},  32'(bus.clk_sel),  32'(sel));
        check({tag, ".sys_hold"}, 32'(bus.sys_hold), 32'(hold));
    endtask

    task automatic expect_win(input string tag, input int count, input bit ok);
        check({tag, ".ref_count"}, 32'(bus.ref_count), 32'(count));
        check({tag, ".ref_ok"},    32'(bus.ref_ok),    32'(ok));
    endtask

    // One controller cycle: place this window's toggles at offsets 20, 35, 50, ...
    task automatic tick();
        int pos;
        pos = cyc % WIN;
        if (pos >= 20 && (pos - 20) % 15 == 0 && (pos - 20) / 15 < n_edges)
            bus.ref_toggle = ~bus.ref_toggle;
        @(posedge clk_debug);
        #1;
        cyc++;
        if (bus.clk_sel !== last_sel) begin
            check("hold_at_sel_change", 32'(bus.sys_hold), 32'd1);
            last_sel = bus.clk_sel;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic window(input string tag, input int edges, input bit ok);
        n_edges = edges;
        run_to(cyc - (cyc % WIN) + WIN);
        expect_win(tag, edges, ok);
    endtask

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.force_int  = 1'b0;
        bus.ref_toggle = 1'b0;
        bus.pll_lock   = 1'b0;
        repeat (3) tick();
        expect_out("reset", 0, 1'b0, 1'b1);
        expect_win("reset", 0, 1'b0);
        reset = 1'b0;
        cyc   = 0;

        // Internal bring-up without a reference.
        run_to(10);
        bus.pll_lock = 1'b1;
        run_to(63);  expect_out("hold_int_min", 0, 1'b0, 1'b1);
        run_to(64);  expect_out("int_entry",    1, 1'b0, 1'b0);
        window("no_ref", 0, 1'b0);
        expect_out("no_ref_int", 1, 1'b0, 1'b0);

        // Tolerance boundaries; the bad 269 window wipes the streak from 252.
        bus.enable = 1'b1;
        window("cnt251", 251, 1'b0);
        window("cnt252", 252, 1'b1);
        window("cnt269", 269, 1'b0);
        window("cnt268", 268, 1'b1);
        window("good_a", 260, 1'b1);
        expect_out("streak2_int", 1, 1'b0, 1'b0);
        window("good_b", 260, 1'b1);
        expect_out("streak3_int", 1, 1'b0, 1'b0);

        // force_int lands with the qualifying window end, then is released.
        n_edges = 260;
        run_to(32767);
        bus.force_int = 1'b1;
        run_to(32768); expect_win("qual_win", 260, 1'b1);
        run_to(32770); expect_out("forced_int",  1, 1'b0, 1'b0);
        run_to(32772); expect_out("forced_int2", 1, 1'b0, 1'b0);
        bus.force_int = 1'b0;
        run_to(32773); expect_out("switch_entry", 2, 1'b1, 1'b1);
        run_to(32836); expect_out("switch_hold",  2, 1'b1, 1'b1);
        run_to(32837); expect_out("ext_entry",    3, 1'b0 ^ 1'b1, 1'b0);

        // One-cycle reset while running external.
        run_to(32845);
        reset = 1'b1;
        tick();
        expect_out("mid_reset", 0, 1'b0, 1'b1);
        expect_win("mid_reset", 0, 1'b0);
        reset = 1'b0;
        cyc   = 0;
        run_to(63);    expect_out("rst_hold",  0, 1'b0, 1'b1);
        run_to(64);    expect_out("rst_int",   1, 1'b0, 1'b0);
        window("rq1", 260, 1'b1);
        window("rq2", 260, 1'b1);
        window("rq3", 260, 1'b1);
        window("rq4", 260, 1'b1);
        expect_out("rq4_int", 1, 1'b0, 1'b0);

        // PLL never locks in SWITCH: abandon after exactly LOCK_TIMEOUT cycles.
        bus.pll_lock = 1'b0;
        run_to(16385); expect_out("tmo_switch",   2, 1'b1, 1'b1);
        run_to(32768); expect_out("tmo_last",     2, 1'b1, 1'b1);
        run_to(32769); expect_out("tmo_fallback", 4, 1'b0, 1'b1);
        run_to(32770); expect_out("tmo_hold_int", 0, 1'b0, 1'b1);
        bus.pll_lock = 1'b1;
        run_to(32833); expect_out("tmo_rehold",   0, 1'b0, 1'b1);
        run_to(32834); expect_out("tmo_int",      1, 1'b0, 1'b0);

        // Requalify, then lose the reference while external.
        run_to(45056); expect_out("requal3_int", 1, 1'b0, 1'b0);
        run_to(49152); expect_out("requal4_int", 1, 1'b0, 1'b0);
        n_edges = 0;
        run_to(49153); expect_out("sw2_entry", 2, 1'b1, 1'b1);
        run_to(49216); expect_out("sw2_hold",  2, 1'b1, 1'b1);
        run_to(49217); expect_out("ext2",      3, 1'b1, 1'b0);
        run_to(53247); expect_out("ext2_last", 3, 1'b1, 1'b0);
        run_to(53248);
        expect_out("loss_fallback", 4, 1'b0, 1'b1);
        expect_win("loss_win", 0, 1'b0);
        run_to(53249); expect_out("loss_hold_int", 0, 1'b0, 1'b1);
        run_to(53312); expect_out("loss_rehold",   0, 1'b0, 1'b1);
        run_to(53313); expect_out("loss_int",      1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
